led_seq_ctrl: RTL

Sequencing controller for the board LED pattern register. It synchronizes and debounces the slide switches and decodes them into a pattern operation. It generates the step tick from a programmable prescaler and supports pause/run. It issues step, op and load commands to the LED datapath, re-seeding shift patterns that have emptied to zero.

---
 rtl/led_seq_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: switch sync/debounce, op decode, step prescaler and pause/run FSM.
// Define LED_SEQ_DEBOUNCE_EN to debounce the switch vector; otherwise sw_acc follows sw_sync.
//
//   state | meaning
//   INIT  | one cycle after reset, clears the pattern via load
//   RUN   | prescaler running, issues step/load on each tick
//   PAUSE | prescaler frozen, no strobes

module led_seq_ctrl #(
    parameter int LED_SIZE   = 8,
    parameter int SW_SIZE    = 8,
    parameter int TICK_DIV   = 100000000,
    parameter int DEB_CYCLES = 1000000,
    parameter int SEED       = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SW_SIZE-1:0]  sw,
    input  logic                pause,
    input  logic [LED_SIZE-1:0] led_cur,
    output logic                step,
    output logic [2:0]          op,
    output logic                load,
    output logic [LED_SIZE-1:0] load_val,
    output logic [1:0]          state
);

    localparam int DIV_W = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);
    localparam logic [LED_SIZE-1:0] SEED_V = LED_SIZE'(SEED);

    localparam logic [2:0] OP_HOLD = 3'd0;
    localparam logic [2:0] OP_SHL  = 3'd1;
    localparam logic [2:0] OP_SHR  = 3'd2;
    localparam logic [2:0] OP_INV  = 3'd3;
    localparam logic [2:0] OP_INC  = 3'd4;

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    state_t             st;
    logic [DIV_W-1:0]   div_cnt;
    logic [SW_SIZE-1:0] sw_meta, sw_sync, sw_acc;
    logic               pause_meta, pause_sync;
    logic [2:0]         op_dec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta    <= '0;
            sw_sync    <= '0;
            pause_meta <= 1'b0;
            pause_sync <= 1'b0;
        end else begin
            sw_meta    <= sw;
            sw_sync    <= sw_meta;
            pause_meta <= pause;
            pause_sync <= pause_meta;
        end
    end

`ifdef LED_SEQ_DEBOUNCE_EN
    localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_CYCLES - 1);

    logic [SW_SIZE-1:0] sw_prev;
    logic [DEB_W-1:0]   deb_cnt;

    // Counter saturates at DEB_MAX; while saturated the stable value keeps being accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_prev <= '0;
            deb_cnt <= '0;
            sw_acc  <= '0;
        end else begin
            sw_prev <= sw_sync;
            if (sw_sync != sw_prev) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_MAX) begin
                sw_acc <= sw_sync;
            end else begin
                deb_cnt <= deb_cnt + DEB_W'(1);
            end
        end
    end
`else
    assign sw_acc = sw_sync;
`endif

    always_comb begin
        op_dec = OP_INC;
        if (sw_acc == SW_SIZE'(1))
            op_dec = OP_HOLD;
        else if (sw_acc == SW_SIZE'(2))
            op_dec = OP_SHL;
        else if (sw_acc == SW_SIZE'(4))
            op_dec = OP_SHR;
        else if (sw_acc == SW_SIZE'(8))
            op_dec = OP_INV;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st       <= S_INIT;
            div_cnt  <= '0;
            step     <= 1'b0;
            op       <= OP_HOLD;
            load     <= 1'b0;
            load_val <= '0;
        end else begin
            step <= 1'b0;
            load <= 1'b0;
            case (st)
                S_INIT: begin
                    load     <= 1'b1;
                    load_val <= '0;
                    st       <= S_RUN;
                end
                S_RUN: begin
                    // Pause takes priority over a coincident tick; the count is kept.
                    if (pause_sync) begin
                        st <= S_PAUSE;
                    end else if (div_cnt == DIV_MAX) begin
                        div_cnt <= '0;
                        if ((op_dec == OP_SHL || op_dec == OP_SHR) && led_cur == '0) begin
                            load     <= 1'b1;
                            load_val <= SEED_V;
                        end else begin
                            step <= 1'b1;
                            op   <= op_dec;
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                S_PAUSE: begin
                    if (!pause_sync)
                        st <= S_RUN;
                end
                default: st <= S_INIT;
            endcase
        end
    end

    assign state = st;

endmodule
